// File: rtl/mac_seq_ctrl.sv
// Host-side sequencer for a non-pipelined int8/fp16 MAC: configures the datapath,
// streams operand pairs through it, drains, reads the result and hands it back.
module mac_seq_ctrl #(
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             job_mode,
  input  logic [LEN_W-1:0] job_len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             mac_cfg,
  output logic             mac_mode,
  output logic             mac_enable,
  output logic             mac_valid,
  output logic             mac_read,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_out,
  input  logic             mac_error,
  output logic [15:0]      result,
  output logic             result_err,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    READ   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // With len>0 the first DRAIN cycle still carries the final beat, so DRAIN is one cycle longer.
  localparam logic [3:0] DRAIN_LAST_BEAT  = 4'(DRAIN_CYCLES);
  localparam logic [3:0] DRAIN_LAST_EMPTY = 4'(DRAIN_CYCLES - 1);

  state_t           state_reg;
  state_t           state_next;
  logic             mode_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] beat_cnt_reg;
  logic [3:0]       drain_cnt_reg;
  logic             valid_reg;
  logic [15:0]      a_reg;
  logic [15:0]      b_reg;
  logic [15:0]      result_reg;
  logic             err_reg;

  logic             start_accept;
  logic             beat_accept;
  logic             last_beat;
  logic             len_zero;
  logic             drain_done;

  assign len_zero     = (len_reg == '0);
  assign start_accept = (state_reg == IDLE) && start;
  assign beat_accept  = op_valid && op_ready;
  assign last_beat    = beat_accept && (beat_cnt_reg == (len_reg - LEN_W'(1)));
  assign drain_done   = (drain_cnt_reg == (len_zero ? DRAIN_LAST_EMPTY : DRAIN_LAST_BEAT));

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = CFG;
      CFG:     state_next = len_zero ? DRAIN : STREAM;
      STREAM:  if (last_beat) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = READ;
      READ:    state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    op_ready     = 1'b0;
    mac_cfg      = 1'b0;
    mac_enable   = 1'b0;
    mac_read     = 1'b0;
    result_valid = 1'b0;
    unique case (state_reg)
      IDLE: begin
      end
      CFG: begin
        busy    = 1'b1;
        mac_cfg = 1'b1;
      end
      STREAM: begin
        busy       = 1'b1;
        mac_enable = 1'b1;
        op_ready   = (beat_cnt_reg < len_reg);
      end
      DRAIN: begin
        busy       = 1'b1;
        mac_enable = 1'b1;
      end
      READ: begin
        busy       = 1'b1;
        mac_enable = 1'b1;
        mac_read   = 1'b1;
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      len_reg       <= '0;
      beat_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      valid_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (start_accept) begin
        mode_reg     <= job_mode;
        len_reg      <= job_len;
        beat_cnt_reg <= '0;
      end else if (beat_accept) begin
        beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
      end

      // Operand registers hold their last value through valid gaps.
      valid_reg <= beat_accept;
      if (beat_accept) begin
        a_reg <= op_a;
        b_reg <= op_b;
      end

      if ((state_reg == DRAIN) && !drain_done) begin
        drain_cnt_reg <= drain_cnt_reg + 4'd1;
      end else begin
        drain_cnt_reg <= '0;
      end

      if (state_reg == READ) begin
        result_reg <= mac_out;
        err_reg    <= mac_error;
      end
    end
  end

  assign mac_mode   = mode_reg;
  assign mac_valid  = valid_reg;
  assign mac_a      = a_reg;
  assign mac_b      = b_reg;
  assign result     = result_reg;
  assign result_err = err_reg;

  cfg_valid_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(mac_cfg && mac_valid));
  read_qualified: assert property (@(posedge clk) disable iff (!rst_n)
    mac_read |-> (mac_enable && !mac_valid));

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: the stimulus side queues expected MAC beats,
// job configs and results; a negedge monitor pops and compares what the DUT presents.
module tb_mac_seq_ctrl;

  localparam int LEN_W = 8;
  localparam int DRAIN = 1;
  localparam int BOUND = 600;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             job_mode = 1'b0;
  logic [LEN_W-1:0] job_len = '0;
  logic             busy;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [15:0]      op_a = '0;
  logic [15:0]      op_b = '0;
  logic             mac_cfg, mac_mode, mac_enable, mac_valid, mac_read;
  logic [15:0]      mac_a, mac_b;
  logic [15:0]      mac_out;
  logic             mac_error;
  logic [15:0]      result;
  logic             result_err, result_valid;
  logic             result_ready = 1'b0;

  // MAC model: the read value is only meaningful during a qualified read strobe.
  logic [15:0] rd_val = 16'h0;
  logic        rd_err = 1'b0;
  assign mac_out   = (mac_read && mac_enable && !mac_valid) ? rd_val : 16'hDEAD;
  assign mac_error = (mac_read && mac_enable && !mac_valid) ? rd_err : 1'b1;

  mac_seq_ctrl #(.LEN_W(LEN_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .job_mode(job_mode), .job_len(job_len),
    .busy(busy), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_cfg(mac_cfg), .mac_mode(mac_mode), .mac_enable(mac_enable), .mac_valid(mac_valid),
    .mac_read(mac_read), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
    .mac_error(mac_error), .result(result), .result_err(result_err),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cycle  = 0;

  logic [31:0] beat_q[$];
  logic        mode_q[$];
  int          len_q[$];
  logic [16:0] res_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    failed++;
    $display("FAIL %s: event with no expectation queued (cycle %0d)", nm, cycle);
  endtask

  always @(posedge clk) cycle++;

  // Monitor
  logic        in_job = 1'b0;
  logic        prev_rv = 1'b0;
  int          cur_len = 0;
  int          beats_seen = 0;
  int          last_evt = 0;
  logic [16:0] cur_res = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_job  = 1'b0;
      prev_rv = 1'b0;
    end else begin
      check("cfg_valid_excl", {63'd0, mac_cfg & mac_valid}, 64'd0);
      if (mac_cfg) begin
        if (mode_q.size() == 0) begin
          flag("unexpected_cfg");
        end else begin
          check("cfg_mode", {63'd0, mac_mode}, {63'd0, mode_q.pop_front()});
          check("cfg_enable", {63'd0, mac_enable}, 64'd0);
          cur_len    = len_q.pop_front();
          beats_seen = 0;
          last_evt   = cycle;
          in_job     = 1'b1;
        end
      end else if (in_job) begin
        check("job_enable", {63'd0, mac_enable}, 64'd1);
        if (mac_valid) begin
          beats_seen++;
          last_evt = cycle;
          if (beat_q.size() == 0) flag("unexpected_beat");
          else check("beat_ab", {32'd0, mac_a, mac_b}, {32'd0, beat_q.pop_front()});
        end
        if (mac_read) begin
          check("read_no_valid", {63'd0, mac_valid}, 64'd0);
          check("beat_count", 64'(beats_seen), 64'(cur_len));
          check("drain_gap", 64'(cycle - last_evt), 64'(DRAIN + 1));
          in_job = 1'b0;
        end
      end else begin
        check("idle_quiet", {62'd0, mac_valid, mac_read}, 64'd0);
      end
      if (result_valid) begin
        check("done_enable", {63'd0, mac_enable}, 64'd0);
        if (!prev_rv) begin
          if (res_q.size() == 0) flag("unexpected_result");
          else begin
            cur_res = res_q.pop_front();
            check("result", {47'd0, result_err, result}, {47'd0, cur_res});
          end
        end else begin
          check("result_hold", {47'd0, result_err, result}, {47'd0, cur_res});
        end
      end
      prev_rv = result_valid;
    end
  end

  task automatic check_all_zero(input string nm);
    check(nm, {13'd0, busy, op_ready, mac_cfg, mac_mode, mac_enable, mac_valid, mac_read,
               result_err, result_valid, mac_a, mac_b, result}, 64'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // gap<0 picks a random 0..2 idle cycles before each beat; abort_at>0 pulls reset
  // right after that beat is accepted.
  task automatic run_job(input logic mode, input int len, input int gap,
                         input logic [15:0] rv, input logic re, input bit poke,
                         input int abort_at, input bit fixed_beats);
    int n;
    int g;
    logic [15:0] a, b;
    wait_idle();
    rd_val = rv;
    rd_err = re;
    mode_q.push_back(mode);
    len_q.push_back(len);
    res_q.push_back({re, rv});
    start    = 1'b1;
    job_mode = mode;
    job_len  = len[LEN_W-1:0];
    @(posedge clk);
    #1;
    start    = 1'b0;
    job_mode = 1'($urandom);
    job_len  = LEN_W'($urandom);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < len; i++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      a = fixed_beats ? 16'(i + 1) : 16'($urandom);
      b = fixed_beats ? 16'(i + 4) : 16'($urandom);
      beat_q.push_back({a, b});
      op_a     = a;
      op_b     = b;
      op_valid = 1'b1;
      if (poke && i == 1) start = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!op_ready && n < BOUND);
      if (!op_ready) begin
        check("op_ready_timeout", {63'd0, op_ready}, 64'd1);
        op_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      start    = 1'b0;
      if (i + 1 == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_stream");
        beat_q.delete();
        mode_q.delete();
        len_q.delete();
        res_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst_n = 1'b1;
        return;
      end
    end
    // Offer surplus beats: the sequencer must refuse them once len is reached.
    op_valid = 1'b1;
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    repeat (2) begin
      @(negedge clk);
      check("ready_after_len", {63'd0, op_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    n = 0;
    while (!result_valid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) begin
      check("result_timeout", {63'd0, result_valid}, 64'd1);
      return;
    end
    @(posedge clk);
    #1;
    if (poke) begin
      start = 1'b1;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      check("busy_in_done", {62'd0, busy, result_valid}, 64'd3);
    end
    repeat ($urandom_range(3, 0)) begin
      @(posedge clk);
      #1;
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("released", {62'd0, busy, result_valid}, 64'd0);
    check("result_kept", {47'd0, result_err, result}, {47'd0, re, rv});
    $display("[TB] job mode=%0d len=%0d result=%h err=%0d", mode, len, result, result_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_job(1'b0, 3, 0, 16'h0020, 1'b0, 1'b0, 0, 1'b1);
    run_job(1'b0, 3, 1, 16'h0020, 1'b0, 1'b0, 0, 1'b1);
    run_job(1'b1, 0, 0, 16'h3C00, 1'b0, 1'b0, 0, 1'b0);
    run_job(1'b0, 3, 0, 16'h1234, 1'b0, 1'b1, 0, 1'b0);
    run_job(1'b0, 3, 0, 16'h5555, 1'b0, 1'b0, 2, 1'b0);
    run_job(1'b1, 3, 0, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    run_job(1'b1, 2, 0, 16'h7C00, 1'b1, 1'b0, 0, 1'b0);
    run_job(1'b0, 2, 0, 16'h0042, 1'b0, 1'b0, 0, 1'b0);
    run_job(1'b1, 255, 0, 16'hBEEF, 1'b0, 1'b0, 0, 1'b0);
    run_job(1'b0, 1, 0, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      run_job(1'($urandom), int'($urandom_range(6, 0)), -1, 16'($urandom),
              1'($urandom), 1'($urandom), 0, 1'b0);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("leftover", 64'(beat_q.size() + mode_q.size() + len_q.size() + res_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
